// File: rtl/div_sequencer_pkg.sv
// div_sequencer_pkg: shared state encoding and step constants for sequenced FPU blocks.
package div_sequencer_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_t;

  localparam logic [5:0] CNT_START   = 6'd1;
  localparam int         CNT_CAPTURE = 30;
endpackage

// File: rtl/div_arb2.sv
// div_arb2: two-way round-robin arbiter; the pointer flips to the loser on each advance.
module div_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic       gnt_id
);
  logic ptr_q, ptr_d;

  always_comb begin
    gnt_id = (req == 2'b10) ? 1'b1 : (req == 2'b01) ? 1'b0 : ptr_q;
    ptr_d  = advance ? ~gnt_id : ptr_q;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ptr_q <= 1'b0;
    else        ptr_q <= ptr_d;
endmodule

// File: rtl/div_sequencer.sv
// div_sequencer: arbitrates two divide requesters onto one multi-cycle divider and
// captures its outputs at a fixed step count.
module div_sequencer
  import div_sequencer_pkg::*;
#(
  parameter int N_CNT_CAPTURE = CNT_CAPTURE
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0,
  input  logic        req1,
  input  logic [31:0] a0,
  input  logic [31:0] b0,
  input  logic [31:0] a1,
  input  logic [31:0] b1,
  output logic        busy,
  output logic        done,
  output logic        done_id,
  output logic [31:0] result,
  output logic        overflow,
  output logic        dv_by_zero,
  output logic [5:0]  div_cnt,
  output logic [31:0] div_a,
  output logic [31:0] div_b,
  input  logic [31:0] div_result,
  input  logic        div_overflow,
  input  logic        div_dv_by_zero
);
  seq_state_t  state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] div_a_q, div_a_d, div_b_q, div_b_d, result_q, result_d;
  logic        done_id_q, done_id_d, overflow_q, overflow_d, dv_by_zero_q, dv_by_zero_d;
  logic        grant, gnt_id;

  assign grant = (state_q == IDLE) && (req0 || req1);

  div_arb2 u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    ({req1, req0}),
    .advance(grant),
    .gnt_id (gnt_id)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    div_a_d      = div_a_q;
    div_b_d      = div_b_q;
    done_id_d    = done_id_q;
    result_d     = result_q;
    overflow_d   = overflow_q;
    dv_by_zero_d = dv_by_zero_q;
    case (state_q)
      IDLE: if (grant) begin
        state_d   = RUN;
        cnt_d     = CNT_START;
        div_a_d   = gnt_id ? a1 : a0;
        div_b_d   = gnt_id ? b1 : b0;
        done_id_d = gnt_id;
      end
      RUN: if (cnt_q == 6'(N_CNT_CAPTURE)) begin
        state_d      = DONE;
        cnt_d        = 6'd0;
        result_d     = div_result;
        overflow_d   = div_overflow;
        dv_by_zero_d = div_dv_by_zero;
      end else begin
        cnt_d = cnt_q + 6'd1;
      end
      DONE: begin
        state_d = IDLE;
        cnt_d   = 6'd0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 6'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= 6'd0;
      div_a_q      <= 32'd0;
      div_b_q      <= 32'd0;
      done_id_q    <= 1'b0;
      result_q     <= 32'd0;
      overflow_q   <= 1'b0;
      dv_by_zero_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      div_a_q      <= div_a_d;
      div_b_q      <= div_b_d;
      done_id_q    <= done_id_d;
      result_q     <= result_d;
      overflow_q   <= overflow_d;
      dv_by_zero_q <= dv_by_zero_d;
    end

  assign busy       = state_q != IDLE;
  assign done       = state_q == DONE;
  assign done_id    = done_id_q;
  assign result     = result_q;
  assign overflow   = overflow_q;
  assign dv_by_zero = dv_by_zero_q;
  assign div_cnt    = cnt_q;
  assign div_a      = div_a_q;
  assign div_b      = div_b_q;
endmodule

// File: tb/tb_div_sequencer.sv
// tb_div_sequencer: directed vectors against a stub divider that is valid only at step 30.
module tb_div_sequencer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic [31:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic        busy, done, done_id, overflow, dv_by_zero;
  logic [31:0] result, div_a, div_b, div_result;
  logic [5:0]  div_cnt;
  logic        div_overflow, div_dv_by_zero;
  logic        stub_o = 1'b0, stub_z = 1'b0;
  logic [31:0] last_res = '0;
  logic        last_o = 1'b0, last_z = 1'b0;
  int          n_vec = 0, n_err = 0;

  always #5 clk = ~clk;

  div_sequencer dut (
    .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .busy(busy), .done(done), .done_id(done_id), .result(result),
    .overflow(overflow), .dv_by_zero(dv_by_zero),
    .div_cnt(div_cnt), .div_a(div_a), .div_b(div_b),
    .div_result(div_result), .div_overflow(div_overflow), .div_dv_by_zero(div_dv_by_zero)
  );

  always_comb begin
    div_result     = (div_cnt == 6'd30) ? (div_a ^ div_b) : 'x;
    div_overflow   = (div_cnt == 6'd30) ? stub_o : 1'bx;
    div_dv_by_zero = (div_cnt == 6'd30) ? stub_z : 1'bx;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_done_id"}, done_id, 0);
    chk({tag, "_result"}, result, 0);
    chk({tag, "_ovf"}, overflow, 0);
    chk({tag, "_dbz"}, dv_by_zero, 0);
    chk({tag, "_cnt"}, div_cnt, 0);
    chk({tag, "_div_a"}, div_a, 0);
    chk({tag, "_div_b"}, div_b, 0);
  endtask

  // Requests must already be raised; drop[i] releases req<i> in the done cycle.
  task automatic do_op(input logic eid, input logic [31:0] ea, input logic [31:0] eb,
                       input logic [1:0] drop, input logic poke);
    int w = 0;
    @(negedge clk);
    while (!busy && w < 4) begin
      @(negedge clk);
      w++;
    end
    chk("grant", busy, 1);
    for (int k = 1; k <= 30; k++) begin
      if (k > 1) @(negedge clk);
      chk("cnt", div_cnt, 32'(k));
      chk("no_early_done", done, 0);
      if (k == 1 || k == 30) begin
        chk("div_a", div_a, ea);
        chk("div_b", div_b, eb);
      end
      if (k == 15) begin
        chk("hold_result", result, last_res);
        chk("hold_ovf", overflow, last_o);
        chk("hold_dbz", dv_by_zero, last_z);
      end
      if (poke && k == 10) a0 = 32'hFFFF_FFFF;
    end
    @(negedge clk);
    chk("done", done, 1);
    chk("done_cnt", div_cnt, 0);
    chk("done_id", done_id, eid);
    chk("result", result, ea ^ eb);
    chk("ovf", overflow, stub_o);
    chk("dbz", dv_by_zero, stub_z);
    last_res = ea ^ eb;
    last_o   = stub_o;
    last_z   = stub_z;
    if (drop[0]) req0 = 1'b0;
    if (drop[1]) req1 = 1'b0;
    @(negedge clk);
    chk("done_pulse_end", done, 0);
    chk("idle_cnt", div_cnt, 0);
    chk("idle_div_a", div_a, ea);
    chk("idle_result", result, last_res);
    chk("idle_ovf", overflow, last_o);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk_zero("post_reset");

    // single request with operand disturbance mid-operation
    a0 = 32'h40C0_0000; b0 = 32'h4000_0000;
    req0 = 1'b1;
    do_op(1'b0, 32'h40C0_0000, 32'h4000_0000, 2'b01, 1'b1);

    // fresh reset, then simultaneous requests: req0 first, then req1
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    last_res = '0;
    a0 = 32'h3F80_0000; b0 = 32'h4080_0000;
    a1 = 32'h4120_0000; b1 = 32'h4040_0000;
    req0 = 1'b1; req1 = 1'b1;
    do_op(1'b0, 32'h3F80_0000, 32'h4080_0000, 2'b01, 1'b0);
    do_op(1'b1, 32'h4120_0000, 32'h4040_0000, 2'b10, 1'b0);

    // both held across three operations: 0, 1, 0
    req0 = 1'b1; req1 = 1'b1;
    do_op(1'b0, 32'h3F80_0000, 32'h4080_0000, 2'b00, 1'b0);
    do_op(1'b1, 32'h4120_0000, 32'h4040_0000, 2'b00, 1'b0);
    do_op(1'b0, 32'h3F80_0000, 32'h4080_0000, 2'b11, 1'b0);

    // flags captured, then held through the next run until its capture
    stub_o = 1'b1; stub_z = 1'b1;
    req1 = 1'b1;
    do_op(1'b1, 32'h4120_0000, 32'h4040_0000, 2'b10, 1'b0);
    stub_o = 1'b0; stub_z = 1'b0;
    req0 = 1'b1;
    do_op(1'b0, 32'h3F80_0000, 32'h4080_0000, 2'b01, 1'b0);

    // reset mid-run aborts with no done pulse
    req0 = 1'b1;
    begin
      int w = 0;
      while (div_cnt != 6'd15 && w < 40) begin
        @(negedge clk);
        w++;
      end
      chk("reach_cnt15", div_cnt, 15);
    end
    rst_n = 1'b0;
    #1;
    chk_zero("abort");
    req0 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abort_no_done", done, 0);
    end
    rst_n = 1'b1;
    last_res = '0; last_o = 1'b0; last_z = 1'b0;
    req1 = 1'b1;
    do_op(1'b1, 32'h4120_0000, 32'h4040_0000, 2'b10, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
